// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
//   md_op_e    : funct3 encodings of the M-extension ops
//   md_state_e : control FSM states
package muldiv_pkg;

    typedef enum logic [2:0] {
        MdMul    = 3'd0,
        MdMulh   = 3'd1,
        MdMulhsu = 3'd2,
        MdMulhu  = 3'd3,
        MdDiv    = 3'd4,
        MdDivu   = 3'd5,
        MdRem    = 3'd6,
        MdRemu   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } md_state_e;

endpackage

// File: rtl/muldiv_if.sv
// Execute-stage <-> multiply/divide unit handshake.
//   start  : issue pulse (master -> slave)
//   op     : funct3 of the M-extension op
//   a, b   : rs1 / rs2 operands
//   flush  : pipeline flush, aborts the op in progress
//   busy   : unit occupied, execute stage stalls
//   done   : one-cycle result-valid pulse
//   result : registered result
interface muldiv_if #(
    parameter int unsigned XLEN = 32
) ();

    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, result
    );

endinterface

// File: rtl/muldiv_operand_prep.sv
// Combinational operand preparation for the multiply/divide unit.
//   op_i, a_i, b_i   : op and raw operands
//   a_mag_o, b_mag_o : operand magnitudes (two's complement negation, wraps)
//   neg_q_o          : product / quotient must be negated
//   neg_r_o          : remainder must be negated
//   is_div_o         : op is a divide/remainder
//   special_o        : divide-by-zero or signed overflow; special_res_o holds the answer
module muldiv_operand_prep
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  md_op_e          op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] a_mag_o,
    output logic [XLEN-1:0] b_mag_o,
    output logic            neg_q_o,
    output logic            neg_r_o,
    output logic            is_div_o,
    output logic            special_o,
    output logic [XLEN-1:0] special_res_o
);

    localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

    logic a_signed, b_signed, a_neg, b_neg;
    logic div_zero, div_ovf;

    always_comb begin
        a_signed = op_i inside {MdMulh, MdMulhsu, MdDiv, MdRem};
        b_signed = op_i inside {MdMulh, MdDiv, MdRem};
        a_neg    = a_signed & a_i[XLEN-1];
        b_neg    = b_signed & b_i[XLEN-1];

        a_mag_o  = a_neg ? (XLEN'(0) - a_i) : a_i;
        b_mag_o  = b_neg ? (XLEN'(0) - b_i) : b_i;
        neg_q_o  = a_neg ^ b_neg;
        neg_r_o  = a_neg;
        is_div_o = op_i[2];

        div_zero = op_i[2] && (b_i == '0);
        div_ovf  = (op_i inside {MdDiv, MdRem}) && (a_i == MinNeg) && (b_i == '1);

        special_o     = div_zero | div_ovf;
        special_res_o = '0;
        // op[1] selects the remainder variants among the divide ops
        if (div_zero) begin
            special_res_o = op_i[1] ? a_i : '1;
        end else if (div_ovf) begin
            special_res_o = op_i[1] ? '0 : MinNeg;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide unit.
//   clk, rst : clock and synchronous active-high reset
//   md       : slave side of muldiv_if (start/op/a/b/flush in, busy/done/result out)
// Multiply is shift-add over a 2*XLEN accumulator {high, multiplier}; divide is
// restoring division over {remainder, quotient}. The last iteration also applies
// the sign fix-up and writes the result, so done follows start by XLEN+1 cycles.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  md
);

    localparam int unsigned CntW = $clog2(XLEN);

    md_state_e         state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    md_op_e            op_q, op_d;
    logic              negq_q, negq_d;
    logic              negr_q, negr_d;
    logic              isdiv_q, isdiv_d;
    logic [XLEN-1:0]   result_q, result_d;

    md_op_e            op_in;
    logic [XLEN-1:0]   a_mag, b_mag, special_res;
    logic              neg_q, neg_r, is_div, special;

    assign op_in = md_op_e'(md.op);

    muldiv_operand_prep #(
        .XLEN(XLEN)
    ) u_prep (
        .op_i         (op_in),
        .a_i          (md.a),
        .b_i          (md.b),
        .a_mag_o      (a_mag),
        .b_mag_o      (b_mag),
        .neg_q_o      (neg_q),
        .neg_r_o      (neg_r),
        .is_div_o     (is_div),
        .special_o    (special),
        .special_res_o(special_res)
    );

    logic [XLEN:0]     mul_sum, div_hi, div_diff;
    logic [2*XLEN-1:0] acc_step, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, final_res;

    // One iteration of the datapath plus the sign fix-up of its outcome
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_hi   = acc_q[2*XLEN-1:XLEN-1];
        div_diff = div_hi - {1'b0, opnd_q};

        if (isdiv_q) begin
            // Borrow in the top bit means the trial subtract failed: keep the remainder
            acc_step = div_diff[XLEN] ? {div_hi[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                      : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            acc_step = {mul_sum, acc_q[XLEN-1:1]};
        end

        prod_fix = negq_q ? ((2*XLEN)'(0) - acc_step) : acc_step;
        quo_fix  = negq_q ? (XLEN'(0) - acc_step[XLEN-1:0]) : acc_step[XLEN-1:0];
        rem_fix  = negr_q ? (XLEN'(0) - acc_step[2*XLEN-1:XLEN]) : acc_step[2*XLEN-1:XLEN];

        unique case (op_q)
            MdMul:                     final_res = prod_fix[XLEN-1:0];
            MdMulh, MdMulhsu, MdMulhu: final_res = prod_fix[2*XLEN-1:XLEN];
            MdDiv, MdDivu:             final_res = quo_fix;
            default:                   final_res = rem_fix;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        op_d     = op_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        isdiv_d  = isdiv_q;
        result_d = result_q;

        unique case (state_q)
            StIdle: begin
                if (md.start && !md.flush) begin
                    op_d    = op_in;
                    negq_d  = neg_q;
                    negr_d  = neg_r;
                    isdiv_d = is_div;
                    cnt_d   = '0;
                    if (special) begin
                        result_d = special_res;
                        state_d  = StDone;
                    end else begin
                        // Low half holds the dividend or the multiplier
                        acc_d   = {{XLEN{1'b0}}, is_div ? a_mag : b_mag};
                        opnd_d  = is_div ? b_mag : a_mag;
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                if (md.flush) begin
                    state_d = StIdle;
                end else begin
                    acc_d = acc_step;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CntW'(XLEN - 1)) begin
                        result_d = final_res;
                        state_d  = StDone;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            op_q     <= MdMul;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            isdiv_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            op_q     <= op_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            isdiv_q  <= isdiv_d;
            result_q <= result_d;
        end
    end

    assign md.busy   = (state_q != StIdle);
    // A flush in the DONE cycle cuts the pulse
    assign md.done   = (state_q == StDone) && !md.flush;
    assign md.result = result_q;

endmodule
